// File: rtl/input_conditioner.sv
// Two-channel switch conditioner: 2-flop synchronizer, per-channel debounce FSM,
// registered rising-edge pulses and a shared modulo-16 rise counter.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       a_raw,
  input  logic       b_raw,
  output logic       a_clean,
  output logic       b_clean,
  output logic       a_rise,
  output logic       b_rise,
  output logic [3:0] rise_count
);

  localparam logic [1:0] STABLE_LOW  = 2'd0;
  localparam logic [1:0] RISE_WAIT   = 2'd1;
  localparam logic [1:0] STABLE_HIGH = 2'd2;
  localparam logic [1:0] FALL_WAIT   = 2'd3;

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_CYCLES);

  logic [1:0] raw_s;
  logic [1:0] clean_s;
  logic [1:0] rise_s;
  logic [3:0] rise_count_r;

  assign raw_s = {b_raw, a_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic       s1_r;
    logic       s2_r;
    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       clean_r;
    logic       clean_nxt_s;
    logic       rise_r;
    logic       rise_nxt_s;

    // Two-flop synchronizer for the asynchronous raw level.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1_r <= 1'b0;
        s2_r <= 1'b0;
      end else begin
        s1_r <= raw_s[ch];
        s2_r <= s1_r;
      end
    end

    // Debounce next-state: count consecutive samples that differ from the clean level.
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      clean_nxt_s = clean_r;
      rise_nxt_s  = 1'b0;
      case (state_r)
        STABLE_LOW: begin
          if (s2_r) begin
            if (DEB_LIMIT == 4'd1) begin
              state_nxt_s = STABLE_HIGH;
              clean_nxt_s = 1'b1;
              rise_nxt_s  = 1'b1;
              cnt_nxt_s   = 4'd0;
            end else begin
              state_nxt_s = RISE_WAIT;
              cnt_nxt_s   = 4'd1;
            end
          end else begin
            cnt_nxt_s = 4'd0;
          end
        end
        RISE_WAIT: begin
          if (s2_r) begin
            if (cnt_r + 4'd1 == DEB_LIMIT) begin
              state_nxt_s = STABLE_HIGH;
              clean_nxt_s = 1'b1;
              rise_nxt_s  = 1'b1;
              cnt_nxt_s   = 4'd0;
            end else begin
              cnt_nxt_s = cnt_r + 4'd1;
            end
          end else begin
            state_nxt_s = STABLE_LOW;
            cnt_nxt_s   = 4'd0;
          end
        end
        STABLE_HIGH: begin
          if (!s2_r) begin
            if (DEB_LIMIT == 4'd1) begin
              state_nxt_s = STABLE_LOW;
              clean_nxt_s = 1'b0;
              cnt_nxt_s   = 4'd0;
            end else begin
              state_nxt_s = FALL_WAIT;
              cnt_nxt_s   = 4'd1;
            end
          end else begin
            cnt_nxt_s = 4'd0;
          end
        end
        FALL_WAIT: begin
          if (!s2_r) begin
            if (cnt_r + 4'd1 == DEB_LIMIT) begin
              state_nxt_s = STABLE_LOW;
              clean_nxt_s = 1'b0;
              cnt_nxt_s   = 4'd0;
            end else begin
              cnt_nxt_s = cnt_r + 4'd1;
            end
          end else begin
            state_nxt_s = STABLE_HIGH;
            cnt_nxt_s   = 4'd0;
          end
        end
        default: begin
          state_nxt_s = STABLE_LOW;
          cnt_nxt_s   = 4'd0;
          clean_nxt_s = 1'b0;
        end
      endcase
    end

    // Debounce state, clean level and rise pulse registers.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_r <= STABLE_LOW;
        cnt_r   <= 4'd0;
        clean_r <= 1'b0;
        rise_r  <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
        clean_r <= clean_nxt_s;
        rise_r  <= rise_nxt_s;
      end
    end

    assign clean_s[ch] = clean_r;
    assign rise_s[ch]  = rise_r;
  end

  // Shared rise counter; simultaneous pulses add two and the count wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rise_count_r <= 4'd0;
    end else begin
      rise_count_r <= rise_count_r + {3'b000, rise_s[0]} + {3'b000, rise_s[1]};
    end
  end

  assign a_clean    = clean_s[0];
  assign b_clean    = clean_s[1];
  assign a_rise     = rise_s[0];
  assign b_rise     = rise_s[1];
  assign rise_count = rise_count_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: a behavioural model pushes expected
// outputs to a scoreboard each cycle, plus directed timing checks per scenario.
module tb_input_conditioner;

  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       a_raw;
  logic       b_raw;
  logic       a_clean;
  logic       b_clean;
  logic       a_rise;
  logic       b_rise;
  logic [3:0] rise_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic       ac;
    logic       bc;
    logic       ar;
    logic       br;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // behavioural model state: raw sample pipeline and run length of differing samples
  bit         m_s1[2];
  bit         m_s2[2];
  bit         m_clean[2];
  bit         m_rise[2];
  int         m_run[2];
  logic [3:0] m_cnt;

  input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock      (clock),
    .reset      (reset),
    .a_raw      (a_raw),
    .b_raw      (b_raw),
    .a_clean    (a_clean),
    .b_clean    (b_clean),
    .a_rise     (a_rise),
    .b_rise     (b_rise),
    .rise_count (rise_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_clean[c] = 1'b0; m_rise[c] = 1'b0; m_run[c] = 0;
    end
    m_cnt = 4'd0;
  endtask

  // Advance the model across one rising edge with the given raw levels.
  task automatic model_edge(input bit a, input bit b);
    bit raw[2];
    raw[0] = a;
    raw[1] = b;
    m_cnt = m_cnt + 4'(m_rise[0]) + 4'(m_rise[1]);
    for (int c = 0; c < 2; c++) begin
      if (m_s2[c] != m_clean[c]) m_run[c]++;
      else m_run[c] = 0;
      m_rise[c] = 1'b0;
      if (m_run[c] >= DEB) begin
        m_clean[c] = ~m_clean[c];
        m_rise[c]  = m_clean[c];
        m_run[c]   = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
  endtask

  // Drive raw levels before the next edge, record the expectation, compare after the edge.
  task automatic tick(input bit a, input bit b, input string tag);
    exp_t e;
    @(negedge clock);
    a_raw = a;
    b_raw = b;
    model_edge(a, b);
    sb_q.push_back('{tag, m_clean[0], m_clean[1], m_rise[0], m_rise[1], m_cnt});
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 4'd1, 4'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".a_clean"}, {3'b000, a_clean}, {3'b000, e.ac});
      check({e.tag, ".b_clean"}, {3'b000, b_clean}, {3'b000, e.bc});
      check({e.tag, ".a_rise"}, {3'b000, a_rise}, {3'b000, e.ar});
      check({e.tag, ".b_rise"}, {3'b000, b_rise}, {3'b000, e.br});
      check({e.tag, ".count"}, rise_count, e.cnt);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".a_clean"}, {3'b000, a_clean}, 4'd0);
    check({tag, ".b_clean"}, {3'b000, b_clean}, 4'd0);
    check({tag, ".a_rise"}, {3'b000, a_rise}, 4'd0);
    check({tag, ".b_rise"}, {3'b000, b_rise}, 4'd0);
    check({tag, ".count"}, rise_count, 4'd0);
  endtask

  // Assert reset from just after an edge, hold over two edges, release off-edge.
  task automatic do_reset(input string tag, input bit a, input bit b);
    reset = 1'b1;
    a_raw = a;
    b_raw = b;
    #1;
    check_zero({tag, ".async"});
    repeat (2) @(posedge clock);
    #1;
    check_zero({tag, ".held"});
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_raw = 1'b0;
    b_raw = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_state");
    #1;
    reset = 1'b0;

    // single rise on A: clean at edge 6, pulse in the cycle after edge 6
    for (int k = 1; k <= 9; k++) begin
      tick(1'b1, 1'b0, $sformatf("rise_a.e%0d", k));
      if (k == 5) check("rise_a.e5_clean", {3'b000, a_clean}, 4'd0);
      if (k == 6) check("rise_a.e6_clean", {3'b000, a_clean}, 4'd1);
      if (k == 6) check("rise_a.e6_pulse", {3'b000, a_rise}, 4'd1);
      if (k == 7) check("rise_a.e7_pulse", {3'b000, a_rise}, 4'd0);
      if (k == 9) check("rise_a.count", rise_count, 4'd1);
    end

    // glitch then steady low on A: first dip rejected, falls at edge 6 of steady low
    for (int k = 1; k <= 2; k++) tick(1'b0, 1'b0, $sformatf("dip.e%0d", k));
    for (int k = 1; k <= 3; k++) tick(1'b1, 1'b0, $sformatf("dip_back.e%0d", k));
    check("dip.rejected", {3'b000, a_clean}, 4'd1);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0, $sformatf("fall_a.e%0d", k));
      if (k == 5) check("fall_a.e5_clean", {3'b000, a_clean}, 4'd1);
      if (k == 6) check("fall_a.e6_clean", {3'b000, a_clean}, 4'd0);
      check($sformatf("fall_a.nopulse%0d", k), {3'b000, a_rise}, 4'd0);
    end
    check("fall_a.count", rise_count, 4'd1);

    // short pulse: three cycles high never debounces
    do_reset("rst1", 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) tick(1'b1, 1'b0, $sformatf("short.hi%0d", k));
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0, $sformatf("short.lo%0d", k));
      check($sformatf("short.clean%0d", k), {3'b000, a_clean}, 4'd0);
      check($sformatf("short.pulse%0d", k), {3'b000, a_rise}, 4'd0);
    end
    check("short.count", rise_count, 4'd0);

    // both channels together
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b1, $sformatf("both.e%0d", k));
      if (k == 6) check("both.e6_a", {3'b000, a_clean}, 4'd1);
      if (k == 6) check("both.e6_b", {3'b000, b_clean}, 4'd1);
      if (k == 6) check("both.e6_pulses", {2'b00, b_rise, a_rise}, 4'd3);
    end
    check("both.count", rise_count, 4'd2);

    // 8 rises on each channel, one channel at a time: wrap after the 16th
    do_reset("rst2", 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, $sformatf("wrap%0d.ahi", i));
      for (int k = 0; k < 7; k++) tick(1'b0, 1'b0, $sformatf("wrap%0d.alo", i));
      check($sformatf("wrap%0d.a_count", i), rise_count, 4'((2 * i + 1) % 16));
      for (int k = 0; k < 7; k++) tick(1'b0, 1'b1, $sformatf("wrap%0d.bhi", i));
      for (int k = 0; k < 7; k++) tick(1'b0, 1'b0, $sformatf("wrap%0d.blo", i));
      check($sformatf("wrap%0d.b_count", i), rise_count, 4'((2 * i + 2) % 16));
    end

    // reset during a pending rise aborts it; raw still high is a new event afterwards
    for (int k = 1; k <= 4; k++) tick(1'b1, 1'b0, $sformatf("abort.e%0d", k));
    do_reset("abort.rst", 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b0, $sformatf("abort_rel.e%0d", k));
      if (k <= 5) check($sformatf("abort_rel.clean%0d", k), {3'b000, a_clean}, 4'd0);
      if (k <= 5) check($sformatf("abort_rel.pulse%0d", k), {3'b000, a_rise}, 4'd0);
      if (k == 6) check("abort_rel.e6_clean", {3'b000, a_clean}, 4'd1);
      if (k == 6) check("abort_rel.e6_pulse", {3'b000, a_rise}, 4'd1);
    end
    check("abort_rel.count", rise_count, 4'd1);

    // independence: B bouncing while A rises must not disturb A's timing
    do_reset("rst3", 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, k[0], $sformatf("indep.e%0d", k));
      if (k == 5) check("indep.e5_a", {3'b000, a_clean}, 4'd0);
      if (k == 6) check("indep.e6_a", {3'b000, a_clean}, 4'd1);
      check($sformatf("indep.b%0d", k), {3'b000, b_clean}, 4'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: the number of consecutive differing synchronized samples required to change a clean level; legal range 1..15.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port a_raw, input, 1 bit: asynchronous raw switch/button level, channel A.
REQ-005 The block SHALL have port b_raw, input, 1 bit: asynchronous raw switch/button level, channel B.
REQ-006 The block SHALL have port a_clean, output, 1 bit: debounced level of channel A, intended to drive the downstream FSM input A.
REQ-007 The block SHALL have port b_clean, output, 1 bit: debounced level of channel B, intended to drive the downstream FSM input B.
REQ-008 The block SHALL have port a_rise, output, 1 bit: one-cycle pulse on a 0->1 transition of a_clean.
REQ-009 The block SHALL have port b_rise, output, 1 bit: one-cycle pulse on a 0->1 transition of b_clean.
REQ-010 The block SHALL have port rise_count, output, 4 bits: total rising events on both channels, modulo 16.

Function
REQ-011 Each channel SHALL pass its raw input through a two-flop synchronizer (s1, then s2); only s2 SHALL feed debounce logic.
REQ-012 Each channel SHALL run an independent 4-state FSM: STABLE_LOW, RISE_WAIT, STABLE_HIGH, FALL_WAIT.
REQ-013 In STABLE_LOW or STABLE_HIGH, an s2 sample equal to the clean level SHALL hold state with counter 0; a differing sample SHALL move to RISE_WAIT or FALL_WAIT respectively with counter 1, except when DEBOUNCE_CYCLES=1, where the clean level SHALL flip on that same edge.
REQ-014 In a WAIT state, a differing sample SHALL increment the counter; when the counter would reach DEBOUNCE_CYCLES the clean level SHALL flip, the counter SHALL clear, and the FSM SHALL enter the opposite STABLE state on that edge.
REQ-015 In a WAIT state, any sample equal to the clean level SHALL clear the counter and return the FSM to the originating STABLE state with no change to the clean level (glitch rejection).
REQ-016 Latency: for a raw level held steady, the clean output SHALL change on rising edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new raw level as edge 1.
REQ-017 x_rise SHALL be registered and high for exactly the one cycle following the edge on which x_clean goes 0->1; a 1->0 transition SHALL produce no pulse.
REQ-018 rise_count SHALL add a_rise+b_rise (0, 1 or 2) each cycle and wrap from 15 to 0; simultaneous pulses on both channels SHALL add 2.
REQ-019 The channels SHALL be fully independent; activity on one channel SHALL never alter the timing of the other.

Reset
REQ-020 While reset is high, all synchronizer flops, counters, a_clean, b_clean, a_rise, b_rise and rise_count SHALL be 0, and both FSMs SHALL be in STABLE_LOW, regardless of clock.
REQ-021 Reset asserted mid-debounce SHALL abort the pending transition; after release, a raw input already high SHALL be treated as a new event and take the full REQ-016 latency.
REQ-022 Reset release SHALL NOT by itself generate any x_rise pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-023 The bench SHALL drive a_raw 0->1 held high -> a_clean=1 at edge 6, a_rise=1 for one cycle after edge 6, rise_count=1.
REQ-024 The bench SHALL drive a_raw high for 3 cycles then low -> a_clean stays 0, a_rise never asserts, rise_count=0.
REQ-025 The bench SHALL raise a_raw and b_raw on the same edge and hold both -> both clean levels at edge 6, both pulses in the same cycle, rise_count=2.
REQ-026 The bench SHALL produce 8 debounced rises on each channel -> rise_count wraps to 0 after the 16th rise.
REQ-027 The bench SHALL assert reset after edge 4 of a pending rise, release it with a_raw still high -> a_clean=0 during reset, rises 6 edges after release, no pulse at release.
REQ-028 The bench SHALL drive a_clean=1 and then a_raw low for 2 cycles, high, then low steadily -> first dip rejected; a_clean=0 at edge 6 of the steady low, no a_rise.
